// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N demultiplexer family.
// Lane slicing is done over a fixed maximum bus width so one helper serves every DATA_W.
package demux_pkg;
   localparam int DATA_W_DEF = 1;
   localparam int SEL_W_DEF  = 3;
   localparam int BUS_MAX_W  = 256;
   localparam int LANE_MAX_W = 32;

   function automatic int n_out(input int sel_w);
      return 2 ** sel_w;
   endfunction

   // Returns lane k of a packed lane bus, zero-extended; callers widen the bus to BUS_MAX_W.
   function automatic logic [LANE_MAX_W-1:0] lane(input logic [BUS_MAX_W-1:0] bus,
                                                  input int k,
                                                  input int w = DATA_W_DEF);
      logic [LANE_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < LANE_MAX_W; i++) begin
         if (i < w) r[i] = bus[k*w + i];
      end
      return r;
   endfunction
endpackage

// File: rtl/demux_1to8_if.sv
// Bundle of the demux data/select inputs and its combinational, registered and sticky outputs.
interface demux_1to8_if
   import demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = SEL_W_DEF
);
   localparam int N_OUT = n_out(SEL_W);

   logic [DATA_W-1:0]       in;
   logic [SEL_W-1:0]        sel;
   logic [N_OUT*DATA_W-1:0] out;
   logic [N_OUT*DATA_W-1:0] out_q;
   logic [N_OUT-1:0]        hit_q;

   modport master (output in, sel, input out, out_q, hit_q);
   modport slave  (input in, sel, output out, out_q, hit_q);
endinterface

// File: rtl/demux_lane_dec.sv
// One-hot lane-enable decoder; an unknown select enables no lane at all.
module demux_lane_dec
   import demux_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF,
   localparam int N_OUT = n_out(SEL_W)
) (
   input  logic [SEL_W-1:0] sel,
   output logic [N_OUT-1:0] en
);
   always_comb begin
      en = '0;
      if (!$isunknown(sel)) en[sel] = 1'b1;
   end
endmodule

// File: rtl/demux_1to8.sv
// Routes `in` onto lane `sel` of `out` (combinational); out_q registers `out`,
// hit_q remembers every lane that has carried nonzero data since reset.
module demux_1to8
   import demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = SEL_W_DEF,
   localparam int N_OUT = n_out(SEL_W)
) (
   input  logic [DATA_W-1:0]       in,
   input  logic [SEL_W-1:0]        sel,
   output logic [N_OUT*DATA_W-1:0] out,
   input  logic                    clk,
   input  logic                    rst,
   output logic [N_OUT*DATA_W-1:0] out_q,
   output logic [N_OUT-1:0]        hit_q
);
   logic [N_OUT-1:0]        lane_en;
   logic [N_OUT*DATA_W-1:0] out_d;
   logic [N_OUT-1:0]        hit_d;

   demux_lane_dec #(.SEL_W(SEL_W)) u_dec (
      .sel (sel),
      .en  (lane_en)
   );

   always_comb begin
      out = '0;
      for (int k = 0; k < N_OUT; k++) begin
         out[k*DATA_W +: DATA_W] = lane_en[k] ? in : '0;
      end
   end

   always_comb begin
      out_d = out;
      hit_d = hit_q;
      for (int k = 0; k < N_OUT; k++) begin
         if (|lane(BUS_MAX_W'(out), k, DATA_W)) hit_d[k] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         hit_q <= '0;
      end else begin
         out_q <= out_d;
         hit_q <= hit_d;
      end
   end
endmodule

// File: tb/tb_demux_1to8.sv
// Bench for demux_1to8: directed vector table, clocked/reset sequences, and a randomized
// run against a lane-arithmetic reference model (instances with DATA_W=1 and DATA_W=4).
module tb_demux_1to8;
   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   demux_1to8_if #(.DATA_W(1), .SEL_W(3)) b1 ();
   demux_1to8_if #(.DATA_W(4), .SEL_W(3)) b4 ();

   demux_1to8 #(.DATA_W(1), .SEL_W(3)) dut (
      .in(b1.in), .sel(b1.sel), .out(b1.out),
      .clk(clk), .rst(rst), .out_q(b1.out_q), .hit_q(b1.hit_q)
   );

   demux_1to8 #(.DATA_W(4), .SEL_W(3)) dut4 (
      .in(b4.in), .sel(b4.sel), .out(b4.out),
      .clk(clk), .rst(rst), .out_q(b4.out_q), .hit_q(b4.hit_q)
   );

   typedef struct {
      logic [3:0] in;
      logic [2:0] sel;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: data shifted up by sel lanes; unknown select yields nothing.
   function automatic logic [63:0] model_out(input int w, input logic [63:0] d, input logic [2:0] s);
      if ($isunknown(s)) return 64'd0;
      return d << (int'(s) * w);
   endfunction

   task automatic tick();
      clk = 1'b1; #5;
      clk = 1'b0; #5;
   endtask

   logic [63:0] prev1, prev4, exp1;
   logic [7:0]  hit_model;

   initial begin
      clk = 1'b0; rst = 1'b1;
      b1.in = '0; b1.sel = '0; b4.in = '0; b4.sel = '0;
      #3;
      check("reset_out_q", 64'(b1.out_q), 64'd0);
      check("reset_hit_q", 64'(b1.hit_q), 64'd0);
      check("reset_out_comb", 64'(b1.out), 64'd0);
      rst = 1'b0; #2;

      // in=0, sel=0 then one edge
      tick();
      check("zero_out_q", 64'(b1.out_q), 64'd0);
      check("zero_hit_q", 64'(b1.hit_q), 64'd0);

      // Combinational table with clock idle
      vecs[0] = '{4'd1, 3'd1, 8'b0000_0010};
      vecs[1] = '{4'd1, 3'd3, 8'b0000_1000};
      vecs[2] = '{4'd1, 3'd5, 8'b0010_0000};
      vecs[3] = '{4'd1, 3'd7, 8'b1000_0000};
      vecs[4] = '{4'd0, 3'd6, 8'b0000_0000};
      vecs[5] = '{4'd1, 3'd0, 8'b0000_0001};
      vecs[6] = '{4'd0, 3'd2, 8'b0000_0000};
      vecs[7] = '{4'd1, 3'd6, 8'b0100_0000};
      for (int i = 0; i < 8; i++) begin
         b1.in = vecs[i].in[0]; b1.sel = vecs[i].sel;
         #1;
         check($sformatf("table_%0d", i), 64'(b1.out), 64'(vecs[i].exp_out));
      end
      check("table_no_edge_hit", 64'(b1.hit_q), 64'd0);

      // Clocked walk over the odd lanes
      b1.in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b1.sel = 3'(2*i + 1);
         #1;
         check($sformatf("walk_out_%0d", i), 64'(b1.out), 64'd1 << (2*i + 1));
         if (i > 0) check($sformatf("walk_lag_%0d", i), 64'(b1.out_q), 64'd1 << (2*i - 1));
         tick();
         check($sformatf("walk_q_%0d", i), 64'(b1.out_q), 64'd1 << (2*i + 1));
      end
      check("walk_hit", 64'(b1.hit_q), 64'hAA);

      // Asynchronous reset between edges
      #2; rst = 1'b1; #1;
      check("arst_out_q", 64'(b1.out_q), 64'd0);
      check("arst_hit_q", 64'(b1.hit_q), 64'd0);
      b1.in = 1'b1; b1.sel = 3'd2; #1;
      check("arst_out_tracks", 64'(b1.out), 64'h04);
      rst = 1'b0; #1;
      check("release_no_edge", 64'(b1.out_q), 64'd0);
      tick();
      check("release_reload", 64'(b1.out_q), 64'h04);
      check("release_hit", 64'(b1.hit_q), 64'h04);

      // Wide lanes and unknown select
      b4.in = 4'hA; b4.sel = 3'd2; #1;
      check("w4_lane2", 64'(b4.out), 64'h0000_0A00);
      tick();
      check("w4_hit", 64'(b4.hit_q), 64'h04);
      b4.sel = 3'bx1x; b1.sel = 3'bx1x; #1;
      check("w4_xsel", 64'(b4.out), model_out(4, 64'(b4.in), b4.sel));
      check("w1_xsel", 64'(b1.out), model_out(1, 64'(b1.in), b1.sel));

      // Randomized run against the reference model
      hit_model = 8'h04;
      b1.sel = 3'd2; b4.sel = 3'd2; #1;
      tick();
      prev1 = model_out(1, 64'(b1.in), b1.sel);
      prev4 = model_out(4, 64'(b4.in), b4.sel);
      for (int n = 0; n < 400; n++) begin
         b1.in  = 1'($urandom_range(0, 1));
         b1.sel = 3'($urandom_range(0, 7));
         b4.in  = 4'($urandom_range(0, 15));
         b4.sel = 3'($urandom_range(0, 7));
         #1;
         exp1 = model_out(1, 64'(b1.in), b1.sel);
         check("rnd_out", 64'(b1.out), exp1);
         check("rnd_out4", 64'(b4.out), model_out(4, 64'(b4.in), b4.sel));
         check("rnd_lag", 64'(b1.out_q), prev1);
         check("rnd_lag4", 64'(b4.out_q), prev4);
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b1; #1;
            check("rnd_arst_q", 64'(b1.out_q), 64'd0);
            check("rnd_arst_hit", 64'(b1.hit_q), 64'd0);
            hit_model = '0;
            rst = 1'b0; #1;
         end
         tick();
         if (b1.in != 0) hit_model[b1.sel] = 1'b1;
         prev1 = exp1;
         prev4 = model_out(4, 64'(b4.in), b4.sel);
         check("rnd_q", 64'(b1.out_q), prev1);
         check("rnd_hit", 64'(b1.hit_q), 64'(hit_model));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
